// File: rtl/dino_pkg.sv
// Shared dino game constants, codes and box helpers.
// Same values the object controller and renderer use.
package dino_pkg;

    typedef enum logic [1:0] {
        GS_INIT  = 2'd0,
        GS_START = 2'd1,
        GS_END   = 2'd2,
        GS_RESET = 2'd3
    } game_state_e;

    typedef enum logic [2:0] {
        LOW_BIRD     = 3'd0,
        HIGH_BIRD    = 3'd1,
        SMALL_CACTUS = 3'd2,
        MANY_CACTUS  = 3'd3,
        BIG_CACTUS   = 3'd4,
        NOTHING      = 3'd5
    } danger_type_e;

    typedef enum logic {
        DINO_SIT   = 1'b0,
        DINO_STAND = 1'b1
    } dino_pose_e;

    localparam int WINDOW_WIDTH  = 640;
    localparam int WINDOW_HEIGHT = 480;

    localparam logic [10:0] DINO_X        = 11'd40;
    localparam logic [10:0] GROUND_Y      = 11'd400;
    localparam logic [10:0] STAND_W       = 11'd44;
    localparam logic [10:0] STAND_H       = 11'd47;
    localparam logic [10:0] SIT_W         = 11'd59;
    localparam logic [10:0] SIT_H         = 11'd30;
    localparam logic [10:0] LOW_BIRD_OFS  = 11'd10;
    localparam logic [10:0] HIGH_BIRD_OFS = 11'd35;

    localparam logic [10:0] BIG_W   = 11'd27;
    localparam logic [10:0] BIG_H   = 11'd50;
    localparam logic [10:0] SMALL_W = 11'd19;
    localparam logic [10:0] SMALL_H = 11'd36;
    localparam logic [10:0] MANY_W  = 11'd77;
    localparam logic [10:0] MANY_H  = 11'd49;
    localparam logic [10:0] BIRD_W  = 11'd47;
    localparam logic [10:0] BIRD_H  = 11'd42;

    typedef struct packed {
        logic [10:0] x_l;
        logic [10:0] x_r;
        logic [10:0] y_t;
        logic [10:0] y_b;
    } box_t;

    typedef struct packed {
        logic       en;
        logic [2:0] typ;
        logic [9:0] pos;
    } danger_t;

    function automatic logic [10:0] sat_sub(
        input logic [10:0] a,
        input logic [10:0] b
    );
        return (a < b) ? 11'd0 : a - b;
    endfunction

    function automatic logic danger_live(input danger_t d);
        return d.en && (d.typ <= 3'd4);
    endfunction

    function automatic box_t danger_box(input danger_t d);
        logic [10:0] w;
        logic [10:0] h;
        logic [10:0] bot;
        box_t        b;
        w   = 11'd0;
        h   = 11'd0;
        bot = GROUND_Y;
        case (d.typ)
            LOW_BIRD: begin
                w   = BIRD_W;
                h   = BIRD_H;
                bot = GROUND_Y - LOW_BIRD_OFS;
            end
            HIGH_BIRD: begin
                w   = BIRD_W;
                h   = BIRD_H;
                bot = GROUND_Y - HIGH_BIRD_OFS;
            end
            SMALL_CACTUS: begin
                w = SMALL_W;
                h = SMALL_H;
            end
            MANY_CACTUS: begin
                w = MANY_W;
                h = MANY_H;
            end
            BIG_CACTUS: begin
                w = BIG_W;
                h = BIG_H;
            end
            default: ;
        endcase
        b.x_r = {1'b0, d.pos};
        b.x_l = sat_sub({1'b0, d.pos}, w);
        b.y_b = bot;
        b.y_t = sat_sub(bot, h);
        return b;
    endfunction

endpackage

// File: rtl/box_overlap.sv
// Half-open 2-D overlap test of two axis-aligned boxes.
// Edges that merely touch do not count as overlap.
module box_overlap
    import dino_pkg::*;
(
    input  box_t a,
    input  box_t b,
    output logic hit
);

    logic x_hit;
    logic y_hit;

    assign x_hit = (a.x_l < b.x_r) && (b.x_l < a.x_r);
    assign y_hit = (a.y_t < b.y_b) && (b.y_t < a.y_b);
    assign hit   = x_hit && y_hit;

endmodule

// File: rtl/collision_detector.sv
// Sequential dino-vs-danger collision scanner.
// One slot per cycle against a snapshot; sticky flag.
module collision_detector
    import dino_pkg::*;
(
    input  logic       game_clk,
    input  logic       rst,
    input  logic [1:0] game_state,
    input  logic [9:0] dino_pos,
    input  logic       dino_behavior,
    input  logic [9:0] danger_pos1,
    input  logic [9:0] danger_pos2,
    input  logic [9:0] danger_pos3,
    input  logic [2:0] danger_type1,
    input  logic [2:0] danger_type2,
    input  logic [2:0] danger_type3,
    input  logic       danger_en1,
    input  logic       danger_en2,
    input  logic       danger_en3,
    output logic       isColision,
    output logic [1:0] hit_slot,
    output logic       scan_done
);

    typedef enum logic [2:0] {
        IDLE,
        SNAP,
        CHK1,
        CHK2,
        CHK3,
        REPORT
    } state_e;

    state_e      state_q;
    state_e      state_d;

    box_t        dino_q;
    box_t        dino_d;
    danger_t     danger_q [3];
    logic [1:0]  hit_idx_q;

    danger_t     cur_danger;
    logic [1:0]  cur_idx;
    box_t        cur_box;
    logic        cur_overlap;
    logic        cur_hit;

    logic        in_start;
    logic        in_clear;

    assign in_start = (game_state == GS_START);
    assign in_clear = (game_state == GS_INIT) ||
                      (game_state == GS_RESET);

    always_comb begin
        dino_d     = '0;
        dino_d.x_l = DINO_X;
        if (dino_behavior == DINO_STAND) begin
            dino_d.x_r = DINO_X + STAND_W;
            dino_d.y_t = sat_sub({1'b0, dino_pos}, STAND_H);
        end else begin
            dino_d.x_r = DINO_X + SIT_W;
            dino_d.y_t = sat_sub({1'b0, dino_pos}, SIT_H);
        end
        dino_d.y_b = {1'b0, dino_pos};
    end

    // One shared overlap unit, fed by whichever slot is under test
    always_comb begin
        cur_danger = '0;
        cur_idx    = 2'd0;
        unique case (1'b1)
            (state_q == CHK1): begin
                cur_danger = danger_q[0];
                cur_idx    = 2'd1;
            end
            (state_q == CHK2): begin
                cur_danger = danger_q[1];
                cur_idx    = 2'd2;
            end
            (state_q == CHK3): begin
                cur_danger = danger_q[2];
                cur_idx    = 2'd3;
            end
            default: ;
        endcase
    end

    assign cur_box = danger_box(cur_danger);

    box_overlap u_overlap (
        .a   (dino_q),
        .b   (cur_box),
        .hit (cur_overlap)
    );

    assign cur_hit = cur_overlap &&
                     danger_live(cur_danger) &&
                     (cur_idx != 2'd0);

    always_ff @(posedge game_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!in_start) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:   if (!isColision) state_d = SNAP;
                SNAP:   state_d = CHK1;
                CHK1:   state_d = CHK2;
                CHK2:   state_d = CHK3;
                CHK3:   state_d = REPORT;
                REPORT: state_d = (hit_idx_q == 2'd0) ? SNAP : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge game_clk or posedge rst) begin
        if (rst) begin
            dino_q     <= '0;
            for (int i = 0; i < 3; i++) danger_q[i] <= '0;
            hit_idx_q  <= 2'd0;
            isColision <= 1'b0;
            hit_slot   <= 2'd0;
            scan_done  <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            if (in_clear) begin
                isColision <= 1'b0;
                hit_slot   <= 2'd0;
            end else if (in_start) begin
                case (state_q)
                    SNAP: begin
                        dino_q      <= dino_d;
                        danger_q[0] <= '{danger_en1, danger_type1, danger_pos1};
                        danger_q[1] <= '{danger_en2, danger_type2, danger_pos2};
                        danger_q[2] <= '{danger_en3, danger_type3, danger_pos3};
                        hit_idx_q   <= 2'd0;
                    end
                    CHK1, CHK2, CHK3: begin
                        if (cur_hit && hit_idx_q == 2'd0) hit_idx_q <= cur_idx;
                    end
                    REPORT: begin
                        scan_done <= 1'b1;
                        if (hit_idx_q != 2'd0) begin
                            isColision <= 1'b1;
                            hit_slot   <= hit_idx_q;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_collision_detector.sv
// Directed self-checking bench for collision_detector.
// Expected values are hand-derived from the box geometry.
module tb_collision_detector;
    import dino_pkg::*;

    logic       game_clk = 1'b0;
    logic       rst;
    logic [1:0] game_state;
    logic [9:0] dino_pos;
    logic       dino_behavior;
    logic [9:0] danger_pos1, danger_pos2, danger_pos3;
    logic [2:0] danger_type1, danger_type2, danger_type3;
    logic       danger_en1, danger_en2, danger_en3;
    logic       isColision;
    logic [1:0] hit_slot;
    logic       scan_done;

    int checks = 0;
    int errors = 0;

    collision_detector dut (
        .game_clk      (game_clk),
        .rst           (rst),
        .game_state    (game_state),
        .dino_pos      (dino_pos),
        .dino_behavior (dino_behavior),
        .danger_pos1   (danger_pos1),
        .danger_pos2   (danger_pos2),
        .danger_pos3   (danger_pos3),
        .danger_type1  (danger_type1),
        .danger_type2  (danger_type2),
        .danger_type3  (danger_type3),
        .danger_en1    (danger_en1),
        .danger_en2    (danger_en2),
        .danger_en3    (danger_en3),
        .isColision    (isColision),
        .hit_slot      (hit_slot),
        .scan_done     (scan_done)
    );

    always #5 game_clk = ~game_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge game_clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_slots();
        danger_pos1 = 10'd0; danger_type1 = 3'd5; danger_en1 = 1'b0;
        danger_pos2 = 10'd0; danger_type2 = 3'd5; danger_en2 = 1'b0;
        danger_pos3 = 10'd0; danger_type3 = 3'd5; danger_en3 = 1'b0;
    endtask

    task automatic set_slot(input int n, input logic [2:0] t,
                            input logic [9:0] p, input logic e);
        case (n)
            1: begin danger_type1 = t; danger_pos1 = p; danger_en1 = e; end
            2: begin danger_type2 = t; danger_pos2 = p; danger_en2 = e; end
            default: begin
                danger_type3 = t; danger_pos3 = p; danger_en3 = e;
            end
        endcase
    endtask

    task automatic game_reset();
        game_state = GS_RESET;
        tick(1);
        clear_slots();
    endtask

    task automatic no_hit_run(input string tag, input int n);
        int seen;
        seen = 0;
        game_state = GS_START;
        for (int c = 0; c < n; c++) begin
            tick(1);
            if (isColision) seen++;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        int pulses, first, last, bad_gap, seen, sd;
        rst = 1'b1;
        game_state = GS_INIT;
        dino_pos = 10'd400;
        dino_behavior = 1'b1;
        clear_slots();
        tick(3);
        chk("rst_flag", isColision, 0);
        chk("rst_slot", hit_slot, 0);
        chk("rst_done", scan_done, 0);
        rst = 1'b0;
        tick(2);
        chk("init_flag", isColision, 0);

        // Standing at ground vs BIG cactus 43..70 x 350..400
        set_slot(1, BIG_CACTUS, 10'd70, 1'b1);
        game_state = GS_START;
        tick(5);
        chk("big_lat_pre", isColision, 0);
        chk("big_done_pre", scan_done, 0);
        tick(1);
        chk("big_flag", isColision, 1);
        chk("big_slot", hit_slot, 1);
        chk("big_done", scan_done, 1);
        tick(1);
        chk("big_done_pulse", scan_done, 0);
        game_reset();
        chk("rst_gs_flag", isColision, 0);
        chk("rst_gs_slot", hit_slot, 0);

        // Jumped dino 293..340 clears the cactus; scans back-to-back
        set_slot(1, BIG_CACTUS, 10'd70, 1'b1);
        dino_pos = 10'd340;
        game_state = GS_START;
        pulses = 0; first = -1; last = -1; bad_gap = 0; seen = 0;
        for (int c = 1; c <= 101; c++) begin
            tick(1);
            if (scan_done) begin
                if (last >= 0 && c - last != 5) bad_gap++;
                if (first < 0) first = c;
                last = c;
                pulses++;
            end
            if (isColision) seen++;
        end
        chk("jump_pulses", pulses, 20);
        chk("jump_first", first, 6);
        chk("jump_gap", bad_gap, 0);
        chk("jump_noflag", seen, 0);
        game_reset();

        // Inputs changing after SNAP only affect the next scan
        set_slot(1, BIG_CACTUS, 10'd70, 1'b1);
        dino_pos = 10'd340;
        game_state = GS_START;
        tick(2);
        dino_pos = 10'd400;
        tick(4);
        chk("snap_done", scan_done, 1);
        chk("snap_hold", isColision, 0);
        tick(5);
        chk("snap_next", isColision, 1);
        chk("snap_slot", hit_slot, 1);
        game_reset();

        // High bird 23..70 x 323..365 in slot 2
        dino_pos = 10'd400;
        dino_behavior = 1'b1;
        set_slot(2, HIGH_BIRD, 10'd70, 1'b1);
        game_state = GS_START;
        tick(6);
        chk("hbird_stand_flag", isColision, 1);
        chk("hbird_stand_slot", hit_slot, 2);
        game_reset();
        dino_behavior = 1'b0;
        set_slot(2, HIGH_BIRD, 10'd70, 1'b1);
        no_hit_run("hbird_sit", 30);
        game_reset();
        dino_behavior = 1'b1;

        // Small cactus edges against dino x_l = 40
        set_slot(1, SMALL_CACTUS, 10'd40, 1'b1);
        no_hit_run("small_40", 12);
        game_reset();
        set_slot(1, SMALL_CACTUS, 10'd41, 1'b1);
        game_state = GS_START;
        tick(6);
        chk("small_41_flag", isColision, 1);
        chk("small_41_slot", hit_slot, 1);
        game_reset();

        set_slot(3, BIG_CACTUS, 10'd70, 1'b0);
        no_hit_run("en0", 12);
        game_reset();
        set_slot(3, NOTHING, 10'd70, 1'b1);
        no_hit_run("type5", 12);
        game_reset();
        set_slot(3, 3'd7, 10'd70, 1'b1);
        no_hit_run("type7", 12);
        game_reset();

        // Slots 1 and 3 both overlap; lowest index wins
        set_slot(1, MANY_CACTUS, 10'd100, 1'b1);
        set_slot(3, SMALL_CACTUS, 10'd60, 1'b1);
        game_state = GS_START;
        tick(6);
        chk("multi_flag", isColision, 1);
        chk("multi_slot", hit_slot, 1);
        game_state = GS_END;
        seen = 0; sd = 0;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            if (!isColision || hit_slot != 2'd1) seen++;
            if (scan_done) sd++;
        end
        chk("end_hold", seen, 0);
        chk("end_nodone", sd, 0);
        game_state = GS_RESET;
        tick(1);
        chk("reset_flag", isColision, 0);
        chk("reset_slot", hit_slot, 0);
        clear_slots();

        // Leaving START mid-scan aborts it
        set_slot(2, BIG_CACTUS, 10'd70, 1'b1);
        game_state = GS_START;
        tick(3);
        game_state = GS_END;
        seen = 0; sd = 0;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            if (isColision) seen++;
            if (scan_done) sd++;
        end
        chk("abort_flag", seen, 0);
        chk("abort_done", sd, 0);
        game_reset();

        // rst during CHK2 with slot 1 already hit
        set_slot(1, BIG_CACTUS, 10'd70, 1'b1);
        game_state = GS_START;
        tick(3);
        rst = 1'b1;
        #1;
        chk("arst_flag", isColision, 0);
        chk("arst_slot", hit_slot, 0);
        chk("arst_done", scan_done, 0);
        sd = 0;
        for (int c = 0; c < 4; c++) begin
            tick(1);
            if (scan_done || isColision) sd++;
        end
        chk("arst_quiet", sd, 0);
        rst = 1'b0;
        tick(5);
        chk("arst_idle_pre", isColision, 0);
        chk("arst_idle_done", scan_done, 0);
        tick(1);
        chk("arst_rescan_flag", isColision, 1);
        chk("arst_rescan_slot", hit_slot, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/collision_detector.md
# collision_detector

Consumes the object state produced by the game object controller (dino position/pose, three danger slots, game state) and produces the `isColision` flag that drives the controller's GAME_START → GAME_END transition. Runs on `game_clk` and scans the three danger slots sequentially against a snapshot of the dino bounding box, one slot per cycle. The flag is sticky until the game is reset.

## Interface
- `DINO_X`, 40: left x of dino box (fixed column)
- `GROUND_Y`, 400: y of ground line; dino_pos and cactus bottoms reference it
- `STAND_W`/`STAND_H`, 44/47: standing dino box
- `SIT_W`/`SIT_H`, 59/30: sitting dino box
- `LOW_BIRD_OFS`, 10: low bird bottom = GROUND_Y − 10
- `HIGH_BIRD_OFS`, 35: high bird bottom = GROUND_Y − 35

- `game_clk` in 1: block clock
- `rst` in 1: asynchronous, active-high reset
- `game_state` in 2: 0 INIT, 1 START, 2 END, 3 RESET
- `dino_pos` in 10: dino bottom y (smaller = higher)
- `dino_behavior` in 1: 0 SIT, 1 STAND
- `danger_pos1..3` in 10 each: danger right-edge x
- `danger_type1..3` in 3 each: 0 LOW_BIRD, 1 HIGH_BIRD, 2 SMALL_CACTUS, 3 MANY_CACTUS, 4 BIG_CACTUS, 5 NOTHING
- `danger_en1..3` in 1 each: slot valid
- `isColision` out 1: sticky collision flag
- `hit_slot` out 2: 1..3 slot that hit first, 0 none
- `scan_done` out 1: one-cycle pulse at end of each scan

## Operation
- FSM states: IDLE, SNAP, CHK1, CHK2, CHK3, REPORT.
- IDLE → SNAP when game_state==START and isColision==0; otherwise stay.
- SNAP: register dino box (x_l=DINO_X, x_r=DINO_X+W, y_b=dino_pos, y_t=dino_pos−H, W/H by dino_behavior) and all nine danger inputs; clear scan-local hit.
- CHKn: evaluate slot n from snapshot; on first hit record n.
- REPORT: if hit, isColision←1, hit_slot←n; pulse scan_done; → SNAP if still START and no hit, else IDLE.
- Danger box: x_r=pos, x_l=pos−width (saturate 0 if pos<width). Widths/heights: BIG 27×50, SMALL 19×36, MANY 77×49, BIRD 47×42. Cactus bottom=GROUND_Y; low/high bird bottom per parameters; top=bottom−height.
- Hit iff en==1, type∈{0..4}, and half-open overlap on both axes: a_l<b_r && b_l<a_r. Types 5–7 never hit.
- All box arithmetic 11-bit unsigned; subtractions underflow-guarded (saturate 0).
- game_state INIT or RESET: isColision←0, hit_slot←0, FSM→IDLE (synchronous, takes priority). END: hold outputs, FSM→IDLE.
- Multiple slots hitting in one scan: lowest slot index reported.

## Timing
- Reset: isColision=0, hit_slot=0, scan_done=0, FSM=IDLE, snapshot registers 0.
- Scan period 5 cycles (SNAP..REPORT), back-to-back while START; first SNAP one cycle after game_state becomes START.
- Collision latency: isColision rises on the cycle after REPORT, ≤ 5 cycles after the overlapping snapshot; inputs changing mid-scan do not affect the current scan.
- rst mid-scan: immediate return to reset values; no pulse emitted.
- game_state leaving START mid-scan: scan aborted, no scan_done, no flag update.

## Structure
- Shared `dino_pkg`: game state codes, danger type codes, dino pose codes, sprite width/height constants, WINDOW_WIDTH/HEIGHT — same values the object controller and renderer use.
- Sub-module `box_overlap`: combinational half-open 2-D overlap of two 11-bit boxes; instantiated once, muxed across CHK states.

## Test plan
- Standing dino at ground (dino_pos=400), slot1 BIG_CACTUS pos=70 en=1, state START → isColision=1, hit_slot=1 within 6 cycles.
- Same cactus, dino_pos=340 (y 293..340 vs 350..400) → no collision over 20 scans, scan_done every 5 cycles.
- Slot2 HIGH_BIRD pos=70 (y 323..365): standing → hit_slot=2; sitting (y 370..400) → no hit.
- Edge: SMALL_CACTUS pos=40 → no hit; pos=41 → hit; en=0 or type=5 with overlap → no hit.
- Slots 1 and 3 both overlapping → hit_slot=1; then game_state=END holds flag; game_state=RESET clears isColision and hit_slot next cycle.
- Assert rst during CHK2 with a pending hit → all outputs 0, FSM IDLE, no scan_done pulse.
